// File: rtl/alu_dispatch.sv
// Command front-end for the 8-bit multi-cycle ALU: buffers host commands in a FIFO,
// issues them one at a time, edge-detects ALU completion and returns tagged responses.
module alu_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err,
  output logic [15:0] alu_in,
  output logic [1:0]  alu_op,
  output logic        alu_valid,
  input  logic        alu_ready,
  input  logic [7:0]  alu_o,
  output logic        busy,
  output logic [7:0]  err_count
);
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [8:0]  TMO_CNT  = 9'(TIMEOUT);

  typedef struct packed {
    logic [3:0] tag;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          iss;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state, state_nxt;
  logic [7:0]    timer;
  logic          ready_q;
  logic          push, pop, alu_edge, tmo;

  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign busy      = (state != IDLE) || (count != '0);
  assign alu_edge  = alu_ready & ~ready_q;
  assign tmo       = ({1'b0, timer} + 9'd1) == TMO_CNT;
  assign alu_in    = {iss.a, iss.b};
  assign alu_op    = iss.op;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_tag, cmd_op, cmd_a, cmd_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // A completion edge in the last WAIT cycle beats the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_edge) state_nxt = CAPTURE;
               else if (tmo) state_nxt = RESP;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      iss       <= '0;
      timer     <= '0;
      ready_q   <= 1'b0;
      alu_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      ready_q   <= alu_ready;
      alu_valid <= (state_nxt == ISSUE);
      rsp_valid <= (state_nxt == RESP);
      if (pop) iss <= mem[rd_ptr];
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 8'd1;
      if (state == CAPTURE) begin
        rsp_data <= alu_o;
        rsp_err  <= 1'b0;
        rsp_tag  <= iss.tag;
      end
      // Timeout answers with zero data and bumps the saturating error counter.
      if (state == WAIT && !alu_edge && tmo) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
        rsp_tag  <= iss.tag;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed scenarios plus random traffic, scored
// against a queue-based model of accepted commands and an ALU with chosen latency.
module tb_alu_dispatch;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic        alu_valid, alu_ready, busy;
  logic [7:0]  cmd_a, cmd_b, rsp_data, alu_o, err_count;
  logic [1:0]  cmd_op, alu_op;
  logic [3:0]  cmd_tag, rsp_tag;
  logic [15:0] alu_in;

  alu_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .alu_in(alu_in), .alu_op(alu_op), .alu_valid(alu_valid),
    .alu_ready(alu_ready), .alu_o(alu_o),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] a; logic [7:0] b; logic [1:0] op; logic [3:0] tag; } acc_t;
  typedef struct { logic [3:0] tag; logic [7:0] data; logic err; int lat; int icyc; } exp_t;

  acc_t acc_q[$];
  exp_t exp_q[$];
  int   n_vec = 0, n_bad = 0;
  int   n_acc = 0, n_iss = 0, n_rsp = 0, err_model = 0;
  int   lat_force = -1, rr_mode = 1, last_acc = 0;
  bit   stale = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk_reset(input string p);
    chk({p, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({p, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({p, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({p, "_rsp_tag"},   32'(rsp_tag),   32'd0);
    chk({p, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({p, "_alu_in"},    32'(alu_in),    32'd0);
    chk({p, "_alu_op"},    32'(alu_op),    32'd0);
    chk({p, "_alu_valid"}, 32'(alu_valid), 32'd0);
    chk({p, "_busy"},      32'(busy),      32'd0);
    chk({p, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  // ALU model: latency k means ready is high in the k-th cycle after the issue cycle.
  int         cnt = 0;
  logic [7:0] res = '0;
  bit         prev_av = 1'b0;
  initial begin
    alu_ready = 1'b0;
    alu_o     = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        cnt = 0; alu_ready = 1'b0; prev_av = 1'b0;
      end else if (alu_valid) begin : issue
        acc_t c;
        exp_t e;
        int   lat;
        chk("av_pulse", 32'(prev_av), 32'd0);
        n_iss++;
        lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, TMO + 2));
        chk("issue_expected", 32'(acc_q.size() != 0), 32'd1);
        if (acc_q.size() != 0) begin
          c = acc_q.pop_front();
          chk("alu_in", 32'(alu_in), 32'({c.a, c.b}));
          chk("alu_op", 32'(alu_op), 32'(c.op));
          res    = alu_ref(c.a, c.b, c.op);
          e.tag  = c.tag;
          e.err  = stale || lat == 0 || lat > TMO;
          e.data = e.err ? 8'h00 : res;
          e.lat  = e.err ? TMO + 1 : lat + 2;
          e.icyc = cyc;
          exp_q.push_back(e);
        end
        cnt       = stale ? 0 : lat;
        alu_ready = stale;
        prev_av   = 1'b1;
      end else begin
        alu_ready = stale || cnt == 1;
        if (cnt == 1) alu_o = res;
        if (cnt > 0) cnt--;
        prev_av = 1'b0;
      end
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: records accepted commands and scores responses at the falling edge.
  bit   prev_rv = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    if (rst) prev_rv = 1'b0;
    else begin
      if (alu_valid) chk("av_during_rsp", 32'(rsp_valid), 32'd0);
      if (cmd_valid) begin
        chk("cmd_ready", 32'(cmd_ready), 32'((n_acc - n_iss) < DEPTH));
        if (cmd_ready) begin
          acc_q.push_back('{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag});
          n_acc++;
          last_acc = cyc;
        end
      end
      if (rsp_valid && !prev_rv) begin
        chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          held = exp_q.pop_front();
          chk("rsp_tag",  32'(rsp_tag),  32'(held.tag));
          chk("rsp_data", 32'(rsp_data), 32'(held.data));
          chk("rsp_err",  32'(rsp_err),  32'(held.err));
          chk("rsp_lat",  32'(cyc - held.icyc), 32'(held.lat));
          if (held.err && err_model < 255) err_model++;
          chk("err_count", 32'(err_count), 32'(err_model));
        end
      end else if (rsp_valid) begin
        chk("rsp_hold", 32'({rsp_tag, rsp_data, rsp_err}), 32'({held.tag, held.data, held.err}));
      end
      if (rsp_valid && rsp_ready) n_rsp++;
      prev_rv = rsp_valid;
    end
  end

  task automatic sync;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      input logic [3:0] tag);
    int n = 0;
    bit ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = cmd_ready;
      n++;
    end
    chk("send_accept", 32'(ok), 32'd1);
    sync;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < max);
    chk("wait_rsp", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((n_acc != n_rsp || rsp_valid) && n < max) begin @(negedge clk); n++; end
    chk("drain", 32'(n_acc - n_rsp), 32'd0);
    sync;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i0, r0, n;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    #12 chk_reset("rst_hold");
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk) chk_reset("rst_rel");
    sync;

    // single command, ALU answers 4 cycles after issue
    rr_mode = 1; lat_force = 4; i0 = n_iss;
    send(8'h05, 8'h03, 2'b00, 4'hA);
    drain(100);
    chk("single_pulses", 32'(n_iss - i0), 32'd1);

    // best-case latency from accept to rsp_valid
    lat_force = 1;
    send(8'h20, 8'h07, 2'b01, 4'h3);
    wait_rsp(50);
    chk("best_lat", 32'(cyc - last_acc), 32'd5);
    drain(50);

    // fill FIFO with responses blocked, then drain in order
    rr_mode = 0; lat_force = 2;
    for (int i = 1; i <= 5; i++) send(8'(i * 3), 8'(i), 2'(i), 4'(i));
    idle(3);
    chk("fill_full", 32'(cmd_ready), 32'd0);
    chk("fill_busy", 32'(busy), 32'd1);
    rr_mode = 1;
    drain(300);

    // timeout, and the completion/timeout boundary
    lat_force = 0;
    send(8'h01, 8'h02, 2'b11, 4'h7);
    drain(100);
    chk("tmo_errcnt", 32'(err_count), 32'd1);
    lat_force = TMO;
    send(8'h44, 8'h11, 2'b01, 4'h8);
    drain(100);
    lat_force = TMO + 1;
    send(8'h45, 8'h12, 2'b10, 4'h9);
    drain(100);
    chk("edge_errcnt", 32'(err_count), 32'd2);

    // stale ready level must time out; a fresh edge afterwards completes
    stale = 1'b1; idle(3); lat_force = 2;
    send(8'h0F, 8'hF0, 2'b11, 4'h5);
    drain(100);
    stale = 1'b0; idle(2); lat_force = 3;
    send(8'h0F, 8'hF0, 2'b11, 4'h6);
    drain(100);
    chk("stale_errcnt", 32'(err_count), 32'd3);

    // backpressure: response held 20 cycles, queued command not issued
    rr_mode = 0; lat_force = 3; r0 = n_rsp;
    send(8'h11, 8'h22, 2'b10, 4'hC);
    wait_rsp(50);
    sync;
    send(8'h33, 8'h44, 2'b11, 4'hD);
    i0 = n_iss;
    idle(20);
    chk("bp_no_issue", 32'(n_iss - i0), 32'd0);
    chk("bp_rsp_held", 32'(rsp_valid), 32'd1);
    rr_mode = 1;
    idle(3);
    chk("bp_one_rsp", 32'(n_rsp - r0), 32'd1);
    drain(100);

    // random traffic
    rr_mode = 2; lat_force = -1;
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 8'($urandom), 2'($urandom), 4'($urandom));
      idle(int'($urandom_range(0, 3)));
    end
    drain(3000);

    // error counter saturation
    rr_mode = 1; lat_force = 0;
    for (int i = 0; i < 260; i++) send(8'(i), 8'(i + 1), 2'(i), 4'(i));
    drain(6000);
    chk("err_sat", 32'(err_count), 32'd255);

    // asynchronous reset in the middle of WAIT with commands still buffered
    lat_force = 0; i0 = n_iss; n = 0;
    send(8'h55, 8'h66, 2'b00, 4'h9);
    while (n_iss == i0 && n < 20) begin idle(1); n++; end
    chk("rst_issue_seen", 32'(n_iss - i0), 32'd1);
    send(8'h77, 8'h88, 2'b01, 4'hE);
    send(8'h99, 8'hAA, 2'b10, 4'hF);
    @(posedge clk); #3 rst = 1'b1;
    #1 chk_reset("rst_mid");
    acc_q.delete(); exp_q.delete();
    n_acc = 0; n_iss = 0; n_rsp = 0; err_model = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    idle(30);
    chk("rst_no_rsp", 32'(n_rsp), 32'd0);
    chk("rst_no_issue", 32'(n_iss), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    lat_force = 2;
    send(8'h12, 8'h34, 2'b00, 4'h2);
    drain(100);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Command front-end for the 8-bit multi-cycle ALU. Accepts operand/opcode commands from the host over a valid/ready handshake and buffers them in a small FIFO. Issues them to the ALU one at a time as a single-cycle `alu_valid` pulse, waits for the ALU's `ready`, and captures the registered ALU result. Returns the result to the host over a second valid/ready handshake, tagged, with a timeout error path.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, 2..16.
- `TIMEOUT`, default 64: maximum WAIT cycles before abort; 1..255.

- `clk`  in  1: clock.
- `rst`  in  1: reset; asynchronous, active-high.
- `cmd_valid`  in  1: host command valid.
- `cmd_ready`  out  1: FIFO not full.
- `cmd_a`  in  8: operand A; goes to ALU `in[15:8]`.
- `cmd_b`  in  8: operand B; goes to ALU `in[7:0]`.
- `cmd_op`  in  2: ALU opcode.
- `cmd_tag`  in  4: host tag, echoed on response.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: host accepts response.
- `rsp_data`  out  8: ALU result; 0 on error.
- `rsp_tag`  out  4: tag of the command being answered.
- `rsp_err`  out  1: timeout occurred.
- `alu_in`  out  16: `{a,b}` to ALU.
- `alu_op`  out  2: opcode to ALU.
- `alu_valid`  out  1: ALU start, one-cycle pulse.
- `alu_ready`  in  1: ALU done.
- `alu_o`  in  8: ALU result register.
- `busy`  out  1: state is not IDLE, or FIFO is non-empty.
- `err_count`  out  8: saturating count of timeouts.

## Operation
- **FIFO.** Each entry is 22 bits: `{tag, op, a, b}`.
  - Push on `cmd_valid & cmd_ready`.
  - `cmd_ready = !full`, combinational from the occupancy count.
  - Push and pop in the same cycle: both take effect, count unchanged.
  - No bypass: a command pushed into an empty FIFO is popped no earlier than the next cycle.
- **FSM states:** IDLE, ISSUE, WAIT, CAPTURE, RESP.
- **IDLE:** if FIFO is non-empty, pop the head into the issue register and go to ISSUE.
- **ISSUE:** `alu_valid=1` for exactly this cycle. Clear the timer and go to WAIT.
- **Drive hold:** `alu_in` and `alu_op` are driven from the issue register and stay stable from ISSUE through the end of CAPTURE.
- **WAIT:** the timer increments each cycle.
  - Completion is a rising edge of `alu_ready`, i.e. `alu_ready=1` with the previous-cycle value 0, using a registered copy. On completion, go to CAPTURE.
  - A level held high from a previous operation never counts as completion.
  - If the timer reaches `TIMEOUT` with no edge: go to RESP with `rsp_err=1`, `rsp_data=0`, and increment `err_count`, saturating at 255.
  - If the edge and the timeout fall in the same cycle, completion wins.
- **CAPTURE:** latch `alu_o` into `rsp_data`, set `rsp_err=0`, go to RESP. The ALU updates `o` on the edge where `ready` is high, so `alu_o` is valid in this cycle.
- **RESP:** `rsp_valid=1`. `rsp_data`, `rsp_tag` and `rsp_err` are held until `rsp_ready`. On handshake, go to IDLE.
- **Ordering:** in-order, with at most one command outstanding at the ALU.

## Timing
- **Reset values:**
  - `cmd_ready=1`.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_tag=0`, `rsp_err=0`.
  - `alu_in=0`, `alu_op=0`, `alu_valid=0`.
  - `busy=0`, `err_count=0`.
  - FIFO empty, state IDLE.
- **Reset mid-operation:** FIFO contents, any in-flight command and any pending response are discarded. `alu_valid` drops immediately (asynchronous). Handshakes during reset are ignored.
- **Best-case latency:** command accepted at cycle 0; IDLE pop at 1; ISSUE at 2; ALU rising edge at cycle 3; CAPTURE at 4; `rsp_valid` at 5.
- **Throughput:** back-to-back commands re-enter ISSUE 2 cycles after the RESP handshake (IDLE, then ISSUE).
- **Backpressure:** `rsp_ready` held low keeps the FSM in RESP. The FIFO still accepts commands until full.
- **Timeout:** with no ALU response, `rsp_valid` rises `TIMEOUT+1` cycles after the ISSUE cycle.
- **All outputs are registered**, except `cmd_ready` and `busy`, which are combinational from registers.

## Test plan
- **Single command:** a=0x05, b=0x03, op=2'b00, tag=0xA. ALU model raises ready 4 cycles after `alu_valid`, with o=0x08. Expect:
  - exactly one `alu_valid` pulse with `alu_in=0x0503`;
  - `rsp_valid` with data=0x08, tag=0xA, err=0.
- **Fill and order:** push 5 commands with `DEPTH=4` and `rsp_ready=0`. Expect:
  - `cmd_ready` low after the 4th buffered entry (one command already in flight);
  - with `rsp_ready` then held high, responses return with tags in push order.
- **Timeout:** ALU never raises ready, `TIMEOUT=8`. Expect `rsp_valid` 9 cycles after ISSUE, err=1, data=0, `err_count`=1.
- **Stale ready:** `alu_ready` held high across ISSUE with no rising edge. Expect a timeout. A later 0→1 edge in a new WAIT completes normally.
- **Reset mid-WAIT:** assert `rst` asynchronously. Expect:
  - all outputs at reset values immediately;
  - FIFO empty;
  - no response emitted for the discarded command.
- **Backpressure:** hold `rsp_ready=0` for 20 cycles during RESP. Expect data/tag stable, no further `alu_valid`, and exactly one response on release.
